spi_slave_sync: RTL and testbench

- Second-generation SPI slave. Runs entirely in the system clock domain and oversamples the SPI pins.
- Adds the following over the current slave:
  - parametrised word width;
  - run-time selection of all four SPI modes;
  - MSB-first or LSB-first bit order;
  - multi-word frames;
  - a buffered transmit handshake;
  - reporting of underrun and aborted frames.
- Sits between an external SPI master and on-chip register or stream logic.

---
 rtl/spi_slave_sync.sv | 188 ++++++++++++++++++
 tb/tb_spi_slave_sync.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_sync.sv
// SPI slave that oversamples sclk/cs/mosi in the system clock domain.
// Supports all four SPI modes, either bit order, multi-word frames and a one-deep transmit holding register.
module spi_slave_sync #(
  parameter int DATA_WIDTH  = 8,
  parameter bit LSB_FIRST   = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  frame_abort,
  output logic                  busy
);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sclk_d, r_cs_d;
  logic                   r_cpol, r_cpha, r_busy;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_done;
  logic [DATA_WIDTH-1:0]  r_rx_sr, r_rx_data;
  logic                   r_rx_valid, r_abort;
  logic [DATA_WIDTH-1:0]  r_hold, r_tx_sr;
  logic                   r_hold_full, r_miso, r_underrun;

  logic                   w_sclk_s, w_cs_s, w_mosi_s;
  logic                   w_sclk_edge, w_lead, w_trail, w_sample, w_shift;
  logic                   w_cs_fall, w_cs_rise, w_word_last, w_load;
  logic [DATA_WIDTH-1:0]  w_load_src;
  logic                   w_no_data;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] tx_advance(input logic [DATA_WIDTH-1:0] w);
    return LSB_FIRST ? {1'b0, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rx_insert(input logic [DATA_WIDTH-1:0] w,
                                                      input logic b);
    return LSB_FIRST ? {b, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], b};
  endfunction

  // Synchronisers plus one-flop history of the last stage for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_fall   = r_cs_d & ~w_cs_s;
  assign w_cs_rise   = ~r_cs_d & w_cs_s;
  assign w_sclk_edge = r_busy & (w_sclk_s ^ r_sclk_d);
  assign w_lead      = w_sclk_edge & (w_sclk_s != r_cpol);
  assign w_trail     = w_sclk_edge & (w_sclk_s == r_cpol);
  assign w_sample    = r_cpha ? w_trail : w_lead;
  assign w_shift     = r_cpha ? w_lead : w_trail;
  assign w_word_last = (r_cnt == CNT_W'(DATA_WIDTH - 1));

  // A word starts at frame start (CPHA=0) or on the first shift edge of a word
  always_comb begin
    w_load = 1'b0;
    if (w_cs_fall)
      w_load = ~mode[0];
    else if (!w_cs_rise)
      w_load = w_shift && (r_cnt == '0);
  end

  always_comb begin
    w_load_src = '0;
    w_no_data  = 1'b0;
    if (r_hold_full)
      w_load_src = r_hold;
    else if (tx_valid)
      w_load_src = tx_data;
    else
      w_no_data = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cpol <= 1'b0;
      r_cpha <= 1'b0;
      r_busy <= 1'b0;
    end else if (w_cs_fall) begin
      r_cpol <= mode[1];
      r_cpha <= mode[0];
      r_busy <= 1'b1;
    end else if (w_cs_rise) begin
      r_busy <= 1'b0;
    end
  end

  // Receive path: the counter wraps one clk after the last sample, together with rx_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_rx_sr    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_abort    <= 1'b0;
      if (w_sample) begin
        r_rx_sr <= rx_insert(r_rx_sr, w_mosi_s);
        r_cnt   <= r_cnt + CNT_W'(1);
        r_done  <= w_word_last;
      end
      if (r_done) begin
        r_rx_data  <= r_rx_sr;
        r_rx_valid <= 1'b1;
        r_cnt      <= '0;
      end
      if (w_cs_fall)
        r_cnt <= '0;
      if (w_cs_rise) begin
        r_cnt   <= '0;
        r_abort <= r_busy && (r_cnt != '0) && !r_done && !(w_sample && w_word_last);
      end
    end
  end

  // Transmit path: holding register, shift register and registered miso
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_tx_sr     <= '0;
      r_miso      <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      if (w_load) begin
        r_tx_sr     <= tx_advance(w_load_src);
        r_miso      <= first_bit(w_load_src);
        r_underrun  <= w_no_data;
        r_hold_full <= 1'b0;
      end else if (w_shift) begin
        r_tx_sr <= tx_advance(r_tx_sr);
        r_miso  <= first_bit(r_tx_sr);
      end
      if (tx_valid && !r_hold_full && !w_load) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end
      if (w_cs_rise)
        r_miso <= 1'b0;
    end
  end

  assign miso        = r_miso;
  assign miso_oe     = r_busy;
  assign busy        = r_busy;
  assign tx_ready    = ~r_hold_full;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign tx_underrun = r_underrun;
  assign frame_abort = r_abort;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: an 8-bit MSB-first and a 12-bit LSB-first slave driven by a bit-level SPI master,
// checked against a word-level model of the holding register, rx words and status pulses.
module tb_spi_slave_sync;
  localparam int HALF = 6;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  mode = 2'd0;
  logic        sclk = 1'b0, mosi = 1'b0, cs_a = 1'b1, cs_b = 1'b1;
  logic        miso_a, oe_a, tx_ready_a, rx_valid_a, udr_a, abt_a, busy_a;
  logic        miso_b, oe_b, tx_ready_b, rx_valid_b, udr_b, abt_b, busy_b;
  logic        tx_valid_a = 1'b0, tx_valid_b = 1'b0;
  logic [7:0]  tx_data_a = '0, rx_data_a;
  logic [11:0] tx_data_b = '0, rx_data_b;

  spi_slave_sync #(.DATA_WIDTH(8), .LSB_FIRST(1'b0), .SYNC_STAGES(SYNC)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .sclk(sclk), .cs(cs_a), .mosi(mosi),
    .miso(miso_a), .miso_oe(oe_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
    .tx_underrun(udr_a), .frame_abort(abt_a), .busy(busy_a));

  spi_slave_sync #(.DATA_WIDTH(12), .LSB_FIRST(1'b1), .SYNC_STAGES(SYNC)) u_dut_b (
    .clk(clk), .rst(rst), .mode(mode), .sclk(sclk), .cs(cs_b), .mosi(mosi),
    .miso(miso_b), .miso_oe(oe_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .tx_underrun(udr_b), .frame_abort(abt_b), .busy(busy_b));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Pulse monitors, sampled on the falling clock edge
  int          rxv_n[2] = '{0, 0};
  int          udr_n[2] = '{0, 0};
  int          abt_n[2] = '{0, 0};
  logic [31:0] rxq0[$];
  logic [31:0] rxq1[$];

  always @(negedge clk) begin
    if (rx_valid_a) begin rxv_n[0]++; rxq0.push_back({24'd0, rx_data_a}); end
    if (rx_valid_b) begin rxv_n[1]++; rxq1.push_back({20'd0, rx_data_b}); end
    if (udr_a) udr_n[0]++;
    if (udr_b) udr_n[1]++;
    if (abt_a) abt_n[0]++;
    if (abt_b) abt_n[1]++;
  end

  // Reference model state per slave
  bit          m_full[2] = '{0, 0};
  logic [31:0] m_hold[2] = '{0, 0};
  logic [31:0] m_rx[2]   = '{0, 0};

  // Frame plan
  logic [31:0] g_mosi[3];
  logic [31:0] g_push_v[3];
  logic [31:0] g_cap[3];
  bit          g_push_en[3];
  bit          g_bypass = 1'b0;
  logic [31:0] g_bypass_v = '0;

  function automatic int dw_of(input int sel);
    return (sel == 1) ? 12 : 8;
  endfunction

  function automatic logic [31:0] dmask(input int sel);
    return (sel == 1) ? 32'hFFF : 32'hFF;
  endfunction

  function automatic int bidx(input int sel, input int i);
    return (sel == 1) ? i : dw_of(sel) - 1 - i;
  endfunction

  function automatic logic miso_of(input int sel);
    return (sel == 1) ? miso_b : miso_a;
  endfunction

  function automatic logic [31:0] rxq_at(input int sel, input int idx);
    logic [31:0] v;
    v = 'x;
    if (sel == 0 && idx < rxq0.size()) v = rxq0[idx];
    if (sel == 1 && idx < rxq1.size()) v = rxq1[idx];
    return v;
  endfunction

  task automatic half();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic set_cs(input int sel, input logic v);
    if (sel == 1) cs_b = v; else cs_a = v;
  endtask

  task automatic drive_tx(input int sel, input logic v, input logic [31:0] d);
    if (sel == 1) begin tx_valid_b = v; tx_data_b = d[11:0]; end
    else begin tx_valid_a = v; tx_data_a = d[7:0]; end
  endtask

  task automatic push_tx(input int sel, input logic [31:0] d);
    drive_tx(sel, 1'b1, d);
    @(negedge clk);
    drive_tx(sel, 1'b0, d);
  endtask

  task automatic push_pre(input int sel, input logic [31:0] d);
    push_tx(sel, d);
    m_full[sel] = 1'b1;
    m_hold[sel] = d & dmask(sel);
    chk("tx_ready_after_write", (sel == 1) ? tx_ready_b : tx_ready_a, 0);
  endtask

  task automatic clear_plan();
    for (int w = 0; w < 3; w++) begin
      g_mosi[w]    = $urandom() & 32'hFFF;
      g_push_en[w] = 1'b0;
      g_push_v[w]  = '0;
    end
  endtask

  // Bit-level SPI master; for CPHA=0 the final trailing edge comes after cs rises
  task automatic master(input int sel, input logic [1:0] md, input int nwords, input int last_bits);
    logic cpol;
    int   nb, dw;
    bit   last;
    cpol = md[1];
    dw   = dw_of(sel);
    for (int w = 0; w < 3; w++) g_cap[w] = '0;
    mode = md;
    sclk = cpol;
    half();
    set_cs(sel, 1'b0);
    if (!md[0]) mosi = g_mosi[0][bidx(sel, 0)];
    if (g_bypass) begin
      repeat (SYNC) @(negedge clk);
      drive_tx(sel, 1'b1, g_bypass_v);
      @(negedge clk);
      drive_tx(sel, 1'b0, g_bypass_v);
    end
    half();
    chk("busy_in_frame", (sel == 1) ? busy_b : busy_a, 1);
    chk("oe_in_frame", (sel == 1) ? oe_b : oe_a, 1);
    for (int w = 0; w < nwords; w++) begin
      nb = (w == nwords - 1) ? last_bits : dw;
      for (int i = 0; i < nb; i++) begin
        last = (w == nwords - 1) && (i == nb - 1);
        if (!md[0]) begin
          g_cap[w][bidx(sel, i)] = miso_of(sel);
          sclk = ~cpol;
          half();
          if (i == 1 && g_push_en[w]) push_tx(sel, g_push_v[w]);
          if (!last) begin
            sclk = cpol;
            if (i == dw - 1) mosi = g_mosi[w + 1][bidx(sel, 0)];
            else mosi = g_mosi[w][bidx(sel, i + 1)];
            half();
          end
        end else begin
          sclk = ~cpol;
          mosi = g_mosi[w][bidx(sel, i)];
          half();
          if (i == 1 && g_push_en[w]) push_tx(sel, g_push_v[w]);
          g_cap[w][bidx(sel, i)] = miso_of(sel);
          sclk = cpol;
          half();
        end
      end
    end
    set_cs(sel, 1'b1);
    half();
    sclk = cpol;
    half();
    half();
  endtask

  // Run one frame and compare everything the model predicts
  task automatic run_frame(input int sel, input logic [1:0] md, input int nwords, input int last_bits);
    int          rx0, udr0, abt0, q0, nb, dw, exp_rx, exp_udr;
    logic [31:0] exp_w, mask;
    dw      = dw_of(sel);
    rx0     = rxv_n[sel];
    udr0    = udr_n[sel];
    abt0    = abt_n[sel];
    q0      = (sel == 1) ? rxq1.size() : rxq0.size();
    exp_rx  = 0;
    exp_udr = 0;
    for (int w = 0; w < 3; w++) begin
      g_mosi[w]   = g_mosi[w] & dmask(sel);
      g_push_v[w] = g_push_v[w] & dmask(sel);
    end
    master(sel, md, nwords, last_bits);
    for (int w = 0; w < nwords; w++) begin
      nb = (w == nwords - 1) ? last_bits : dw;
      if (w == 0 && g_bypass) exp_w = g_bypass_v & dmask(sel);
      else if (m_full[sel]) begin exp_w = m_hold[sel]; m_full[sel] = 1'b0; end
      else begin exp_w = '0; exp_udr++; end
      mask = '0;
      for (int i = 0; i < nb; i++) mask[bidx(sel, i)] = 1'b1;
      chk("miso_word", g_cap[w], exp_w & mask);
      if (g_push_en[w] && nb >= 2) begin m_full[sel] = 1'b1; m_hold[sel] = g_push_v[w]; end
      if (nb == dw) begin
        exp_rx++;
        m_rx[sel] = g_mosi[w];
        chk("rx_word", rxq_at(sel, q0 + exp_rx - 1), g_mosi[w]);
      end
    end
    chk("rx_valid_count", 32'(rxv_n[sel] - rx0), 32'(exp_rx));
    chk("underrun_count", 32'(udr_n[sel] - udr0), 32'(exp_udr));
    chk("abort_count", 32'(abt_n[sel] - abt0), (last_bits < dw) ? 1 : 0);
    chk("tx_ready_end", (sel == 1) ? tx_ready_b : tx_ready_a, m_full[sel] ? 0 : 1);
    chk("busy_end", (sel == 1) ? busy_b : busy_a, 0);
    chk("oe_end", (sel == 1) ? oe_b : oe_a, 0);
    chk("miso_end", miso_of(sel), 0);
    chk("rx_data_end", (sel == 1) ? {20'd0, rx_data_b} : {24'd0, rx_data_a}, m_rx[sel]);
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, "_miso"}, miso_a, 0);
    chk({tag, "_oe"}, oe_a, 0);
    chk({tag, "_tx_ready"}, tx_ready_a, 1);
    chk({tag, "_rx_data"}, rx_data_a, 0);
    chk({tag, "_rx_valid"}, rx_valid_a, 0);
    chk({tag, "_underrun"}, udr_a, 0);
    chk({tag, "_abort"}, abt_a, 0);
    chk({tag, "_busy"}, busy_a, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          sel, nw, lb;
    logic [1:0]  md;
    logic [31:0] saved;

    repeat (3) @(negedge clk);
    check_reset_a("rst");
    chk("rst_b_tx_ready", tx_ready_b, 1);
    chk("rst_b_busy", busy_b, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Mode 0, holding 0xA5, master sends 0x3C
    clear_plan();
    g_mosi[0] = 32'h3C;
    push_pre(0, 32'hA5);
    run_frame(0, 2'd0, 1, 8);
    chk("t1_miso_bits", g_cap[0], 32'hA5);
    chk("t1_rx_data", rx_data_a, 8'h3C);

    // Modes 1..3: master sends 0x96, slave sends 0x5A
    for (int m = 1; m < 4; m++) begin
      clear_plan();
      g_mosi[0] = 32'h96;
      push_pre(0, 32'h5A);
      run_frame(0, 2'(m), 1, 8);
      chk("t2_master_rx", g_cap[0], 32'h5A);
      chk("t2_rx_data", rx_data_a, 8'h96);
    end

    // 12-bit LSB-first slave
    clear_plan();
    g_mosi[0] = 32'h123;
    push_pre(1, 32'h801);
    run_frame(1, 2'd0, 1, 12);
    chk("t3_first_bit", g_cap[0][0], 1);
    chk("t3_last_bit", g_cap[0][11], 1);
    chk("t3_rx_data", rx_data_b, 12'h123);

    // Three-word frame, holding refilled only during word 1
    clear_plan();
    push_pre(0, 32'h11);
    g_push_en[0] = 1'b1;
    g_push_v[0]  = 32'h22;
    run_frame(0, 2'd0, 3, 8);
    chk("t4_word2", g_cap[1], 32'h22);
    chk("t4_word3", g_cap[2], 32'h00);

    // Abort after 5 bits, then a clean 0xFF frame
    clear_plan();
    saved = {24'd0, rx_data_a};
    push_pre(0, 32'h33);
    run_frame(0, 2'd0, 1, 5);
    chk("t5_rx_unchanged", rx_data_a, saved);
    clear_plan();
    g_mosi[0] = 32'hFF;
    run_frame(0, 2'd0, 1, 8);
    chk("t5_rx_ff", rx_data_a, 8'hFF);

    // Reset mid-word, then a bypass frame
    clear_plan();
    push_pre(0, 32'h77);
    mode = 2'd0;
    sclk = 1'b0;
    half();
    cs_a = 1'b0;
    mosi = 1'b1;
    half();
    for (int i = 0; i < 3; i++) begin
      sclk = 1'b1; half();
      sclk = 1'b0; half();
    end
    rst = 1'b1;
    @(negedge clk);
    check_reset_a("t6_midrst");
    cs_a = 1'b1;
    half();
    rst = 1'b0;
    half();
    m_full[0] = 1'b0;
    m_rx[0]   = '0;
    clear_plan();
    g_bypass   = 1'b1;
    g_bypass_v = 32'hC3;
    run_frame(0, 2'd0, 1, 8);
    g_bypass   = 1'b0;
    chk("t6_bypass_word", g_cap[0], 32'hC3);

    // Randomised frames on both slaves
    for (int it = 0; it < 16; it++) begin
      clear_plan();
      sel = $urandom_range(0, 1);
      md  = 2'($urandom_range(0, 3));
      nw  = $urandom_range(1, 3);
      lb  = ($urandom_range(0, 3) == 0) ? $urandom_range(2, dw_of(sel) - 1) : dw_of(sel);
      for (int w = 0; w < 3; w++) begin
        g_push_en[w] = ($urandom_range(0, 1) == 1);
        g_push_v[w]  = $urandom();
      end
      if (!m_full[sel] && $urandom_range(0, 1) == 1) push_pre(sel, $urandom());
      run_frame(sel, md, nw, lb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
